uart_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the UART TX/RX data paths. It replaces the fixed 16-entry buffer with a configurable width and depth, and true full-depth storage (2^ADDR_WIDTH entries). It adds run-time programmable almost-empty/almost-full levels, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. It sits between the UART register interface and the shift engines; Fifo_Status drives interrupt and flow-control logic.

---
 rtl/uart_fifo_param.sv | 116 +++++++++++
 tb/tb_uart_fifo_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// uart_fifo_param: parametrised synchronous FIFO for the UART TX/RX data paths.
// Storage is 2^ADDR_WIDTH entries. Pointers carry an extra wrap bit.
// There are programmable almost-empty and almost-full levels.
// Flush and sticky overflow/underflow flags are also provided.
// Optional feature: define UART_FIFO_FWFT_EN for first-word-fall-through
// output; otherwise Data_Out is a registered read with a one-cycle valid pulse.
module uart_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Write,
   input  logic                  Read,
   input  logic                  Flush,
   input  logic                  Clear_Err,
   input  logic [ADDR_WIDTH:0]   AE_Level,
   input  logic [ADDR_WIDTH:0]   AF_Level,
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  Data_Valid,
   output logic [ADDR_WIDTH:0]   Count,
   output logic [3:0]            Fifo_Status,
   output logic                  Overflow,
   output logic                  Underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  empty;
   logic                  full;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  rd_rej;
   logic                  wr_rej;

   // Occupancy, flags and request acceptance derived from the registered pointers
   always_comb begin
      Count  = wr_ptr - rd_ptr;
      empty  = (Count == '0);
      full   = (Count == FULL_CNT);
      // Flush wins over both requests, so nothing is accepted or flagged then
      rd_acc = !Flush && Read && !empty;
      rd_rej = !Flush && Read && empty;
      // A full FIFO still takes a write when a read frees a slot in the same cycle
      wr_acc = !Flush && Write && (!full || rd_acc);
      wr_rej = !Flush && Write && !wr_acc;
      Fifo_Status = {(Count <= AE_Level), (Count >= AF_Level), full, empty};
   end

   // Pointer register: advance on accepted operations, clear on flush
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array: written only by accepted writes; flush leaves contents alone
   always_ff @(posedge Clk) begin
      if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= Data_In;
   end

   // Sticky error flags: a new error in the same cycle as Clear_Err keeps the flag set
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         Overflow  <= (Overflow  && !Clear_Err) || wr_rej;
         Underflow <= (Underflow && !Clear_Err) || rd_rej;
      end
   end

`ifdef UART_FIFO_FWFT_EN
   // Head word is presented directly; zero while there is nothing to present
   always_comb begin
      Data_Valid = !empty;
      Data_Out   = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
   end
`else
   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic                  vld_p1;

   // Registered read stage: data lands one cycle after the accepted read
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_data_p1 <= '0;
         vld_p1     <= 1'b0;
      end else if (Flush) begin
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= rd_acc;
         if (rd_acc) rd_data_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   // Drive the outputs from the read stage
   always_comb begin
      Data_Out   = rd_data_p1;
      Data_Valid = vld_p1;
   end
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench for uart_fifo_param: stimulus pushes the expected read data,
// a negedge monitor pops and compares whenever the DUT presents a word.
module tb_uart_fifo_param;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] Data_In;
   logic       Write, Read, Flush, Clear_Err;
   logic [4:0] AE_Level, AF_Level;
   logic [7:0] Data_Out;
   logic       Data_Valid;
   logic [4:0] Count;
   logic [3:0] Fifo_Status;
   logic       Overflow, Underflow;

   int n_total = 0;
   int n_pass  = 0;
   int n_pops  = 0;
   logic [7:0] exp_q[$];

   uart_fifo_param dut (
      .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Write(Write), .Read(Read),
      .Flush(Flush), .Clear_Err(Clear_Err), .AE_Level(AE_Level), .AF_Level(AF_Level),
      .Data_Out(Data_Out), .Data_Valid(Data_Valid), .Count(Count),
      .Fifo_Status(Fifo_Status), .Overflow(Overflow), .Underflow(Underflow)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // One clock of stimulus; inputs change 1ns after the rising edge
   task automatic op(input logic w, input logic [7:0] d, input logic r,
                     input logic f, input logic ce);
      Write = w; Data_In = d; Read = r; Flush = f; Clear_Err = ce;
      @(posedge Clk);
      #1;
      Write = 1'b0; Read = 1'b0; Flush = 1'b0; Clear_Err = 1'b0;
   endtask

   // Monitor: compare each presented word against the scoreboard head
   always @(negedge Clk) begin
`ifdef UART_FIFO_FWFT_EN
      if (Reset && Read && Data_Valid) begin
`else
      if (Reset && Data_Valid) begin
`endif
         if (exp_q.size() == 0) begin
            chk("unexpected_data", {24'h0, Data_Out}, 32'hFFFF_FFFF);
         end else begin
            chk("read_data", {24'h0, Data_Out}, {24'h0, exp_q.pop_front()});
            n_pops++;
         end
      end
   end

   initial begin
      logic [7:0] nxt_wr, nxt_rd, last_rd;
      int pops0;
      Reset = 1'b0; Data_In = '0; Write = 0; Read = 0; Flush = 0; Clear_Err = 0;
      AE_Level = 5'd2; AF_Level = 5'd14;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_count", Count, 0);
      chk("rst_status", Fifo_Status, 4'b1001);
      Reset = 1'b1;
      op(0, 8'h00, 0, 0, 0);
      chk("idle_count", Count, 0);
      chk("idle_status", Fifo_Status, 4'b1001);
      chk("idle_dout", Data_Out, 0);
      chk("idle_vld", Data_Valid, 0);
      chk("idle_ovf", Overflow, 0);
      chk("idle_unf", Underflow, 0);

      // Fill: AEmpty drops at 3, AFull rises at 14, Full at 16
      for (int i = 1; i <= 16; i++) begin
         op(1, 8'(i), 0, 0, 0);
         chk("fill_count", Count, i);
         chk("fill_status", Fifo_Status, {(i <= 2), (i >= 14), (i == 16), 1'b0});
      end
      op(1, 8'hAA, 0, 0, 0);
      chk("ovf_set", Overflow, 1);
      chk("ovf_count", Count, 16);

      // Drain in order; 0xAA must not appear
      pops0 = n_pops;
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back(8'(i));
         op(0, 8'h00, 1, 0, 0);
`ifndef UART_FIFO_FWFT_EN
         chk("rd_latency_vld", Data_Valid, 1);
`endif
      end
      op(0, 8'h00, 0, 0, 0);
      chk("drain_pulses", n_pops - pops0, 16);
      chk("drain_status", Fifo_Status, 4'b1001);
      op(0, 8'h00, 1, 0, 0);
      chk("unf_set", Underflow, 1);
      chk("unf_vld", Data_Valid, 0);
`ifdef UART_FIFO_FWFT_EN
      chk("unf_dout", Data_Out, 8'h00);
`else
      chk("unf_dout_hold", Data_Out, 8'h10);
`endif

      // Clear, then clear with a colliding underflow
      op(0, 8'h00, 0, 0, 1);
      chk("clr_ovf", Overflow, 0);
      chk("clr_unf", Underflow, 0);
      op(0, 8'h00, 1, 0, 1);
      chk("clr_collide_unf", Underflow, 1);
      chk("clr_collide_ovf", Overflow, 0);
      op(0, 8'h00, 0, 0, 1);

      // Full with simultaneous read+write: 0x55 comes out last
      for (int i = 0; i < 16; i++) op(1, 8'h21 + 8'(i), 0, 0, 0);
      chk("refill_full", Fifo_Status[1], 1);
      exp_q.push_back(8'h21);
      op(1, 8'h55, 1, 0, 0);
      chk("full_rw_count", Count, 16);
      chk("full_rw_ovf", Overflow, 0);
      for (int i = 1; i < 16; i++) begin
         exp_q.push_back(8'h21 + 8'(i));
         op(0, 8'h00, 1, 0, 0);
      end
      exp_q.push_back(8'h55);
      op(0, 8'h00, 1, 0, 0);
      op(0, 8'h00, 0, 0, 0);
      chk("full_rw_drained", Count, 0);

      // Empty with simultaneous read+write: read rejected, write taken
      op(1, 8'h33, 1, 0, 0);
      chk("empty_rw_unf", Underflow, 1);
      chk("empty_rw_count", Count, 1);
      exp_q.push_back(8'h33);
      op(0, 8'h00, 1, 0, 0);
      last_rd = 8'h33;

      // Wrap-around at occupancy 3..5
      nxt_wr = 8'h40; nxt_rd = 8'h40;
      for (int i = 0; i < 4; i++) begin op(1, nxt_wr, 0, 0, 0); nxt_wr++; end
      for (int k = 0; k < 40; k++) begin
         if (k % 4 == 0 || k % 4 == 3) begin
            op(1, nxt_wr, 0, 0, 0); nxt_wr++;
         end else begin
            exp_q.push_back(nxt_rd); last_rd = nxt_rd; nxt_rd++;
            op(0, 8'h00, 1, 0, 0);
         end
      end
      chk("wrap_count", Count, 4);

      // Flush beats a same-cycle write; error flags untouched
      op(1, 8'h99, 0, 1, 0);
      chk("flush_count", Count, 0);
      chk("flush_status", Fifo_Status, 4'b1001);
      chk("flush_vld", Data_Valid, 0);
      chk("flush_ovf", Overflow, 0);
      chk("flush_unf", Underflow, 1);
`ifdef UART_FIFO_FWFT_EN
      chk("flush_dout", Data_Out, 8'h00);
`else
      chk("flush_dout_hold", Data_Out, last_rd);
`endif

      // Levels above depth: AEmpty stuck 1, AFull stuck 0
      AE_Level = 5'd31; AF_Level = 5'd31;
      #1;
      chk("lvl_hi_empty", Fifo_Status, 4'b1001);
      op(1, 8'h5A, 0, 0, 0);
      chk("lvl_hi_one", Fifo_Status, 4'b1000);
      exp_q.push_back(8'h5A);
      op(0, 8'h00, 1, 0, 0);
      AE_Level = 5'd2; AF_Level = 5'd14;

      // Asynchronous reset in the middle of a cycle
      op(1, 8'h11, 0, 0, 0);
      op(1, 8'h12, 0, 0, 0);
      #2 Reset = 1'b0;
      #1;
      chk("midrst_count", Count, 0);
      chk("midrst_status", Fifo_Status, 4'b1001);
      chk("midrst_unf", Underflow, 0);
      @(posedge Clk);
      #1 Reset = 1'b1;

`ifdef UART_FIFO_FWFT_EN
      op(1, 8'h7E, 0, 0, 0);
      chk("fwft_dout", Data_Out, 8'h7E);
      chk("fwft_vld", Data_Valid, 1);
      exp_q.push_back(8'h7E);
      op(0, 8'h00, 1, 0, 0);
      chk("fwft_vld_after", Data_Valid, 0);
`endif

      op(0, 8'h00, 0, 0, 0);
      op(0, 8'h00, 0, 0, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
